// File: rtl/cfg_sequencer_pkg.sv
// Shared parameters for the configuration path: frame header constant,
// default config bus widths (also used by the clock divider), the sequencer
// state encoding and the frame checksum helper.
package CFG_params;

  localparam logic [7:0] FRAME_HEADER         = 8'hA5;
  localparam int         DEFAULT_CFG_ADDR_W   = 8;
  localparam int         DEFAULT_CFG_DATA_W   = 16;
  localparam int         DEFAULT_TIMEOUT      = 100000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA_H = 3'd2,
    ST_DATA_L = 3'd3,
    ST_CHK    = 3'd4,
    ST_ISSUE  = 3'd5
  } state_t;

  // Checksum carried in the last byte of a frame.
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] data_h,
                                           input logic [7:0] data_l);
    return addr ^ data_h ^ data_l;
  endfunction

endpackage

// File: rtl/cfg_sequencer_if.sv
// Config write bus between the sequencer (master) and the clock divider
// (slave).
//   c_addr  : config address
//   c_data  : config data
//   c_valid : write request, held until accepted
//   c_ready : slave accepts the request
// Handshake: a transfer completes on the rising edge where c_valid and
// c_ready are both 1; once c_valid is raised, c_addr/c_data/c_valid stay
// constant until that edge, and c_ready has no meaning while c_valid is 0.
interface cfg_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_data;
  logic              c_valid;
  logic              c_ready;

  modport master (output c_addr, output c_data, output c_valid, input c_ready);
  modport slave  (input c_addr, input c_data, input c_valid, output c_ready);
endinterface

// File: rtl/cfg_sequencer_timeout_counter.sv
// Inter-byte timeout counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : an accepted byte restarts the count
//   enable     : counting allowed (inside a frame); held at 0 otherwise
//   expire     : TIMEOUT_CYCLES idle cycles have elapsed on this edge
module cfg_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the number of idle edges already seen, so the edge where it
  // equals TIMEOUT_CYCLES-1 is the TIMEOUT_CYCLES-th idle edge.
  assign expire = enable && !clear && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end
endmodule

// File: rtl/cfg_sequencer.sv
// UART-frame to config-write sequencer.
// Parses frames A5, ADDR, DATA_H, DATA_L, CHK (CHK = ADDR^DATA_H^DATA_L) and
// issues one config write per good frame on the cfg_bus master port.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_data    : received byte, qualified by rx_valid (one-cycle strobe)
//   cfg_bus    : config write master (c_addr, c_data, c_valid, c_ready)
//   busy       : high whenever the FSM is not IDLE
//   frame_err  : one-cycle pulse on checksum error or inter-byte timeout
//   overrun    : one-cycle pulse for each byte dropped while issuing
//   cfg_count  : completed config writes, wraps 255->0
//   state      : current FSM state (debug)
module cfg_sequencer
  import CFG_params::*;
#(
  parameter int WIDTH_CONFIG_ADDR = DEFAULT_CFG_ADDR_W,
  parameter int WIDTH_CONFIG_DATA = DEFAULT_CFG_DATA_W,
  parameter int TIMEOUT_CYCLES    = DEFAULT_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  cfg_sequencer_if.master        cfg_bus,
  output logic                   busy,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [7:0]             cfg_count,
  output state_t                 state
);

  logic [7:0]  addr_q;
  logic [7:0]  data_h_q;
  logic [7:0]  data_l_q;
  logic [15:0] data_word;
  logic        in_frame;
  logic        expire;

  assign data_word = {data_h_q, data_l_q};
  assign in_frame  = (state == ST_ADDR) || (state == ST_DATA_H) ||
                     (state == ST_DATA_L) || (state == ST_CHK);

  cfg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (rx_valid),
    .enable (in_frame),
    .expire (expire)
  );

  // A byte on the expiry edge wins: each frame state tests rx_valid first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      busy            <= 1'b0;
      frame_err       <= 1'b0;
      overrun         <= 1'b0;
      cfg_count       <= 8'd0;
      addr_q          <= 8'd0;
      data_h_q        <= 8'd0;
      data_l_q        <= 8'd0;
      cfg_bus.c_valid <= 1'b0;
      cfg_bus.c_addr  <= '0;
      cfg_bus.c_data  <= '0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_valid && rx_data == FRAME_HEADER) begin
            state <= ST_ADDR;
            busy  <= 1'b1;
          end
        end
        ST_ADDR: begin
          if (rx_valid) begin
            addr_q <= rx_data;
            state  <= ST_DATA_H;
          end else if (expire) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_DATA_H: begin
          if (rx_valid) begin
            data_h_q <= rx_data;
            state    <= ST_DATA_L;
          end else if (expire) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_DATA_L: begin
          if (rx_valid) begin
            data_l_q <= rx_data;
            state    <= ST_CHK;
          end else if (expire) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_CHK: begin
          if (rx_valid) begin
            if (rx_data == frame_chk(addr_q, data_h_q, data_l_q)) begin
              state           <= ST_ISSUE;
              cfg_bus.c_valid <= 1'b1;
              cfg_bus.c_addr  <= addr_q[WIDTH_CONFIG_ADDR-1:0];
              cfg_bus.c_data  <= data_word[WIDTH_CONFIG_DATA-1:0];
            end else begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
            end
          end else if (expire) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            frame_err <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // c_valid is always 1 here, so c_ready alone completes the write.
          if (rx_valid) begin
            overrun <= 1'b1;
          end
          if (cfg_bus.c_ready) begin
            cfg_bus.c_valid <= 1'b0;
            cfg_count       <= cfg_count + 8'd1;
            state           <= ST_IDLE;
            busy            <= 1'b0;
          end
        end
        default: begin
          state           <= ST_IDLE;
          busy            <= 1'b0;
          cfg_bus.c_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cfg_sequencer.md
CFG_SEQUENCER -- requirements
Module: cfg_sequencer

Interface
REQ-001 SHALL have parameter WIDTH_CONFIG_ADDR, default 8: config address width, legal 1..8.
REQ-002 SHALL have parameter WIDTH_CONFIG_DATA, default 16: config data width, legal 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 100000: maximum idle clk cycles between bytes inside a frame.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port rx_data, input, 8: received UART byte.
REQ-007 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-008 SHALL have port c_addr, output, WIDTH_CONFIG_ADDR: config address to the clock divider.
REQ-009 SHALL have port c_data, output, WIDTH_CONFIG_DATA: config data to the clock divider.
REQ-010 SHALL have port c_valid, output, 1: config write request.
REQ-011 SHALL have port c_ready, input, 1: the clock divider accepts the request.
REQ-012 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 SHALL have port frame_err, output, 1: one-cycle pulse on a checksum error or timeout.
REQ-014 SHALL have port overrun, output, 1: one-cycle pulse when a byte is dropped during ISSUE.
REQ-015 SHALL have port cfg_count, output, 8: count of completed config writes, wrapping 255->0.

Function
REQ-016 SHALL parse each frame as: header 0xA5, ADDR, DATA_H, DATA_L, CHK.
REQ-017 SHALL consume bytes only on cycles where rx_valid=1.
REQ-018 SHALL implement FSM states IDLE, ADDR, DATA_H, DATA_L, CHK and ISSUE.
REQ-019 SHALL, in IDLE, move to ADDR on byte 0xA5 and silently discard any other byte.
REQ-020 SHALL advance ADDR->DATA_H->DATA_L->CHK, one state per accepted byte, latching each byte.
REQ-021 SHALL, in CHK, compute ADDR^DATA_H^DATA_L and compare it with the received CHK byte.
REQ-022 SHALL, on a checksum match, go to ISSUE with c_valid=1 on the cycle after the CHK byte is accepted.
REQ-023 SHALL, on a checksum mismatch, go to IDLE and pulse frame_err for one cycle.
REQ-024 SHALL drive c_addr from ADDR[WIDTH_CONFIG_ADDR-1:0].
REQ-025 SHALL drive c_data from {DATA_H,DATA_L}[WIDTH_CONFIG_DATA-1:0].
REQ-026 SHALL hold c_addr and c_data stable from the cycle c_valid rises until the transfer completes.
REQ-027 SHALL complete a transfer on the first rising edge where c_valid&c_ready=1.
REQ-028 SHALL, on transfer completion, deassert c_valid, increment cfg_count and return to IDLE.
REQ-029 SHALL never deassert c_valid before the transfer completes; there is no timeout in ISSUE.
REQ-030 SHALL ignore c_ready whenever c_valid=0.
REQ-031 SHALL, while in ISSUE, drop every incoming byte (0xA5 included) and pulse overrun for each one.
REQ-032 SHALL run a timeout counter in ADDR, DATA_H, DATA_L and CHK, clearing it on every accepted byte.
REQ-033 SHALL, when TIMEOUT_CYCLES cycles pass without a byte, go to IDLE and pulse frame_err.
REQ-034 SHALL, when a byte arrives on the same cycle the timeout expires, give the byte priority (counter clears).
REQ-035 SHALL keep the timeout counter cleared in IDLE and ISSUE.
REQ-036 SHALL size the timeout counter as $clog2(TIMEOUT_CYCLES+1) bits.
REQ-037 SHALL treat 0xA5 received mid-frame as ordinary data, not as a resync.

Reset
REQ-038 SHALL, on rst_n=0, immediately force state=IDLE, c_valid=0, c_addr=0, c_data=0 and busy=0.
REQ-039 SHALL, on rst_n=0, immediately force frame_err=0, overrun=0, cfg_count=0 and the timeout counter to 0.
REQ-040 SHALL, when reset occurs mid-frame or mid-ISSUE, abandon the transaction with no pulse and no count.
REQ-041 SHALL require no post-reset recovery cycles; the first rx_valid after release is parsed.

Structure
REQ-042 SHALL take the header constant (0xA5) and the state encoding from a shared package, CFG_params.
REQ-043 SHALL take the default width parameters from the same package as the clock divider uses.
REQ-044 SHALL use one sub-module, cfg_timeout_counter (clear, enable, expire).
REQ-045 SHALL instantiate cfg_sequencer upstream of the clock divider, on the same clock as the clock divider's config interface.

Verification
REQ-046 SHALL cover a good frame: A5 03 12 34 25 with c_ready=1 -> c_valid=1 for one cycle, c_addr=03, c_data=1234, cfg_count=1.
REQ-047 SHALL cover a delayed ready: the same frame with c_ready low for 10 cycles -> c_valid and data held stable for 10 cycles, completion on cycle 11.
REQ-048 SHALL cover a bad checksum: A5 03 12 34 00 -> frame_err pulses once, c_valid never rises, cfg_count unchanged.
REQ-049 SHALL cover a timeout: TIMEOUT_CYCLES=20, A5 03 then 20 idle cycles -> frame_err pulse and IDLE; a following full frame is accepted.
REQ-050 SHALL cover overrun: bytes 55 66 sent during ISSUE -> two overrun pulses, and the pending write completes unchanged.
REQ-051 SHALL cover reset mid-ISSUE: rst_n low while c_valid=1 -> c_valid=0 immediately and cfg_count=0.
